conv_relu_maxpool_2x2: RTL and testbench
========================================

// Module: conv_relu_maxpool_2x2
// PURPOSE
//  Downstream stage of the 1x1 convolution block: consumes its channel-planar float32 output stream.
//  Applies ReLU, then 2x2 stride-2 max pooling per channel. Emits a pooled channel-planar stream.
//  Uses a half-width line buffer, so there is no full-frame storage.
// PARAMETERS
//  DATA_WIDTH    32   pixel word width, IEEE-754 single precision
//  IMAGE_WIDTH   16   input columns per channel; must be even
//  IMAGE_HEIGHT  16   input rows per channel; must be even
//  CHANNEL_NUM   512  channels per frame
// PORTS
//  clk         in   1           clock, all logic on rising edge
//  reset       in   1           reset, synchronous, active-high
//  valid_in    in   1           pxl_in valid this cycle
//  pxl_in      in   DATA_WIDTH  input pixel; order is channel, then row, then column (column fastest)
//  pxl_out     out  DATA_WIDTH  pooled pixel; order is channel, then row/2, then col/2
//  valid_out   out  1           pxl_out valid, single-cycle pulse per pooled pixel
//  frame_done  out  1           pulse coincident with the last pooled pixel of channel CHANNEL_NUM-1
// BEHAVIOUR
//  - Reset state:
//    - pxl_out=0, valid_out=0, frame_done=0.
//    - col, row and ch counters = 0; hold register = 0.
//    - Line-buffer contents are don't-care; they are always written before they are read.
//  - No backpressure: valid_in may be deasserted for any number of cycles.
//    - Counters and all state advance only on valid_in=1.
//  - ReLU, applied to every accepted pixel: r = pxl_in[DATA_WIDTH-1] ? 0 : pxl_in.
//    - -0.0 maps to +0.0.
//    - A NaN with sign 0 passes through as a large value.
//  - Max comparison: after ReLU all values are non-negative.
//    - max() is an unsigned integer compare of the 32-bit words; no float unit is used.
//  - Counters:
//    - col 0..IMAGE_WIDTH-1, row 0..IMAGE_HEIGHT-1, ch 0..CHANNEL_NUM-1, nested with col fastest.
//    - All wrap to 0 after their last value; ch wraps after the last pixel of the frame.
//  - Even column: hold <= r.
//  - Odd column: h = max(hold, r) is the horizontal pair maximum.
//    - Even row: linebuf[col>>1] <= h. No output.
//    - Odd row: pxl_out <= max(linebuf[col>>1], h); valid_out <= 1.
//  - Latency: valid_out rises exactly 1 cycle after the odd-row, odd-column input is accepted.
//    - valid_out=0 in all other cycles.
//  - Throughput: (IMAGE_WIDTH/2)*(IMAGE_HEIGHT/2) outputs per channel.
//    - Output rate is at most one per 2 accepted inputs.
//  - Line buffer: IMAGE_WIDTH/2 entries of DATA_WIDTH, one write port and one read port.
//    - A read and a write to the same address never occur in the same cycle; row parity separates them.
//  - frame_done: 1 in the same cycle as the valid_out of the pixel for ch=CHANNEL_NUM-1, last row, last col.
//  - Channel boundary: no state carries across channels.
//    - hold and linebuf are fully overwritten before use.
//    - Back-to-back channels need no idle cycles.
//  - Reset mid-frame: any partial pool window is discarded and counters return to 0.
//    - The next accepted pixel is treated as ch0, row0, col0.
//  - pxl_out holds its last value when valid_out=0.
// TESTING
//  1. 4x4, 1 channel, pixels 1.0..16.0 raster, no gaps.
//     -> outputs 6.0, 8.0, 14.0, 16.0, each 1 cycle after inputs 6, 8, 14, 16; frame_done with 16.0.
//  2. 4x4, all pixels -3.5 (0xC0600000), plus one window containing -0.0 (0x80000000).
//     -> all outputs 0x00000000.
//  3. Same stream as test 1 with valid_in toggled 1/0 every cycle.
//     -> identical output values and order; valid_out 1 cycle after each qualifying input.
//  4. 4x4, CHANNEL_NUM=3, channel k pixel = (k+1)*pixel value of test 1, contiguous.
//     -> 12 outputs in channel order; frame_done only on the 12th (48.0).
//  5. Reset asserted after 9 pixels of a 4x4 frame, then a full clean frame is sent.
//     -> no output from the partial frame window; clean frame gives the test 1 result.
//  6. 16x16, 512 channels, random signed floats.
//     -> match a reference model bit-exactly; 32768 valid_out pulses; a single frame_done.

Source files
------------

// File: rtl/conv_relu_maxpool_2x2_if.sv
// ---------------------------------------------------------------------------
// conv_relu_maxpool_2x2_if
//
// Pixel-stream bundle between the convolution stage, the ReLU/max-pool stage
// and whatever consumes the pooled stream.
//
// Signals
//   valid_in    pxl_in carries an accepted pixel this cycle
//   pxl_in      input pixel word (channel, row, column order; column fastest)
//   pxl_out     pooled pixel word, held while valid_out is low
//   valid_out   single-cycle pulse per pooled pixel
//   frame_done  pulse with the last pooled pixel of the last channel
//
// Modports
//   master  the side that feeds pixels and observes the pooled stream
//   slave   the pooling stage itself
// ---------------------------------------------------------------------------
interface conv_relu_maxpool_2x2_if #(
   parameter int DATA_WIDTH = 32
);

   logic                  valid_in;
   logic [DATA_WIDTH-1:0] pxl_in;
   logic [DATA_WIDTH-1:0] pxl_out;
   logic                  valid_out;
   logic                  frame_done;

   modport master (
      output valid_in,
      output pxl_in,
      input  pxl_out,
      input  valid_out,
      input  frame_done
   );

   modport slave (
      input  valid_in,
      input  pxl_in,
      output pxl_out,
      output valid_out,
      output frame_done
   );

endinterface

// File: rtl/conv_relu_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// conv_relu_maxpool_2x2
//
// Sits behind the 1x1 convolution block and consumes its channel-planar
// float32 stream. Every accepted pixel goes through ReLU, then each channel
// is reduced by 2x2 stride-2 max pooling. Only half a row of pair maxima is
// stored (line buffer of IMAGE_WIDTH/2 words), never a full frame.
//
// Because ReLU clears every negative word, all values reaching the max
// stage have sign bit 0, and for such IEEE-754 words an unsigned integer
// compare orders them the same way as a float compare. No float unit is
// needed. A positive NaN simply behaves as a very large value.
//
// Ports
//   clk        clock, everything on the rising edge
//   reset      synchronous, active-high
//   bus        conv_relu_maxpool_2x2_if slave modport
//                valid_in / pxl_in            input stream, no backpressure
//                pxl_out / valid_out          pooled stream, one pulse each
//                frame_done                   last pooled pixel of the frame
//
// Parameters
//   DATA_WIDTH    pixel word width (IEEE-754 single precision)
//   IMAGE_WIDTH   input columns per channel, even, at least 4
//   IMAGE_HEIGHT  input rows per channel, even, at least 2
//   CHANNEL_NUM   channels per frame
// ---------------------------------------------------------------------------
module conv_relu_maxpool_2x2 #(
   parameter int DATA_WIDTH   = 32,
   parameter int IMAGE_WIDTH  = 16,
   parameter int IMAGE_HEIGHT = 16,
   parameter int CHANNEL_NUM  = 512
) (
   input  logic                     clk,
   input  logic                     reset,
   conv_relu_maxpool_2x2_if.slave   bus
);

   localparam int COL_W  = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
   localparam int ROW_W  = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;
   localparam int CH_W   = (CHANNEL_NUM  > 1) ? $clog2(CHANNEL_NUM)  : 1;
   localparam int LB_N   = IMAGE_WIDTH / 2;
   localparam int LB_AW  = (LB_N > 1) ? $clog2(LB_N) : 1;

   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH  - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNEL_NUM   - 1);

   // Position of the pixel currently on pxl_in within the frame.
   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [CH_W-1:0]       ch;

   // Even-column pixel waiting for its odd-column partner.
   logic [DATA_WIDTH-1:0] hold;

   // Horizontal pair maxima of the most recent even row of the channel.
   logic [DATA_WIDTH-1:0] linebuf [LB_N];

   logic [DATA_WIDTH-1:0] relu_val;
   logic [DATA_WIDTH-1:0] pair_max;
   logic [DATA_WIDTH-1:0] lb_rd;
   logic [DATA_WIDTH-1:0] pool_max;
   logic [LB_AW-1:0]      lb_addr;
   logic                  col_last;
   logic                  row_last;
   logic                  ch_last;

   // Datapath for the pixel on the bus this cycle: ReLU, the horizontal
   // pair maximum against the held even-column pixel, and the vertical
   // maximum against the pair stored for the even row above. The line
   // buffer is addressed by the pair index, i.e. the column without its
   // parity bit; odd rows only read it and even rows only write it, so
   // the two ports never touch the same entry in one cycle.
   always_comb begin
      relu_val = bus.pxl_in[DATA_WIDTH-1] ? '0 : bus.pxl_in;
      pair_max = (relu_val > hold) ? relu_val : hold;
      lb_addr  = col[COL_W-1:1];
      lb_rd    = linebuf[lb_addr];
      pool_max = (pair_max > lb_rd) ? pair_max : lb_rd;
      col_last = (col == COL_LAST);
      row_last = (row == ROW_LAST);
      ch_last  = (ch  == CH_LAST);
   end

   // Counters, hold register and the registered output stream. Nothing
   // moves unless valid_in is high, so the producer may insert gaps freely.
   // An even column parks its pixel in hold; the odd column completes the
   // pair and, on an odd row, the full 2x2 window, which is presented one
   // cycle later together with frame_done on the very last window of the
   // last channel. A reset anywhere drops the partial window and restarts
   // the position at channel 0, row 0, column 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         col            <= '0;
         row            <= '0;
         ch             <= '0;
         hold           <= '0;
         bus.pxl_out    <= '0;
         bus.valid_out  <= 1'b0;
         bus.frame_done <= 1'b0;
      end else begin
         bus.valid_out  <= 1'b0;
         bus.frame_done <= 1'b0;
         if (bus.valid_in) begin
            if (!col[0]) begin
               hold <= relu_val;
            end else if (row[0]) begin
               bus.pxl_out    <= pool_max;
               bus.valid_out  <= 1'b1;
               bus.frame_done <= col_last && row_last && ch_last;
            end

            if (col_last) begin
               col <= '0;
               if (row_last) begin
                  row <= '0;
                  ch  <= ch_last ? '0 : ch + 1'b1;
               end else begin
                  row <= row + 1'b1;
               end
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // Line buffer write port. Only even rows store their pair maxima; the
   // contents are never reset because every entry is rewritten on the even
   // row before the odd row below reads it, also across channel boundaries.
   always_ff @(posedge clk) begin
      if (!reset && bus.valid_in && col[0] && !row[0]) begin
         linebuf[lb_addr] <= pair_max;
      end
   end

endmodule

// File: tb/tb_conv_relu_maxpool_2x2.sv
// ---------------------------------------------------------------------------
// tb_conv_relu_maxpool_2x2
//
// Three instances of the pooling stage with different geometry:
//   dut 0: 4x4, 1 channel     dut 1: 4x4, 3 channels
//   dut 2: 16x16, 24 channels, random signed floats with random gaps
// A reference model stores each channel as a plain 2-D array of ReLU
// values and computes the max of each 2x2 window when its last pixel is
// fed; the expected result is due one cycle after that pixel is accepted.
// ---------------------------------------------------------------------------
module tb_conv_relu_maxpool_2x2;

   localparam int NDUT = 3;

   logic        clk;
   logic        reset;

   logic        vIn  [NDUT];
   logic [31:0] pIn  [NDUT];
   logic        vOut [NDUT];
   logic [31:0] pOut [NDUT];
   logic        fDone[NDUT];

   int checks;
   int errors;

   // Reference model state.
   int          gW [NDUT] = '{4, 4, 16};
   int          gH [NDUT] = '{4, 4, 16};
   int          gC [NDUT] = '{1, 3, 24};
   int          mCol[NDUT];
   int          mRow[NDUT];
   int          mCh [NDUT];
   logic [31:0] win [NDUT][16][16];

   // Expectations handed from the stimulus side to the monitor.
   logic        drvValid[NDUT];
   logic [31:0] drvData [NDUT];
   logic        drvDone [NDUT];
   logic        expValid[NDUT];
   logic [31:0] expData [NDUT];
   logic        expDone [NDUT];
   logic [31:0] lastData[NDUT];

   int          pulses[NDUT];
   int          dones [NDUT];
   logic [31:0] cap0[$];
   logic [31:0] cap1[$];

   conv_relu_maxpool_2x2_if #(.DATA_WIDTH(32)) bus0 ();
   conv_relu_maxpool_2x2_if #(.DATA_WIDTH(32)) bus1 ();
   conv_relu_maxpool_2x2_if #(.DATA_WIDTH(32)) bus2 ();

   conv_relu_maxpool_2x2 #(
      .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM(1)
   ) dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));

   conv_relu_maxpool_2x2 #(
      .DATA_WIDTH(32), .IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .CHANNEL_NUM(3)
   ) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

   conv_relu_maxpool_2x2 #(
      .DATA_WIDTH(32), .IMAGE_WIDTH(16), .IMAGE_HEIGHT(16), .CHANNEL_NUM(24)
   ) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));

   assign bus0.valid_in = vIn[0];
   assign bus0.pxl_in   = pIn[0];
   assign bus1.valid_in = vIn[1];
   assign bus1.pxl_in   = pIn[1];
   assign bus2.valid_in = vIn[2];
   assign bus2.pxl_in   = pIn[2];

   assign vOut[0]  = bus0.valid_out;
   assign pOut[0]  = bus0.pxl_out;
   assign fDone[0] = bus0.frame_done;
   assign vOut[1]  = bus1.valid_out;
   assign pOut[1]  = bus1.pxl_out;
   assign fDone[1] = bus1.frame_done;
   assign vOut[2]  = bus2.valid_out;
   assign pOut[2]  = bus2.pxl_out;
   assign fDone[2] = bus2.frame_done;

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point of the bench.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Exact float32 encoding of a small non-negative integer.
   function automatic logic [31:0] floatOfInt(input int n);
      int e;
      int m;
      if (n == 0) return 32'h0;
      e = 0;
      while ((n >> (e + 1)) != 0) e++;
      m = (n << (23 - e)) & 32'h007F_FFFF;
      return {1'b0, 8'(127 + e), m[22:0]};
   endfunction

   // Feed one cycle to dut d (all others idle) and update the model.
   task automatic applyStimulus(input int d, input logic [31:0] px, input bit valid);
      logic [31:0] r;
      logic [31:0] m;
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) vIn[k] = 1'b0;
      vIn[d] = valid;
      pIn[d] = px;
      if (valid) begin
         r = px[31] ? 32'h0 : px;
         win[d][mRow[d]][mCol[d]] = r;
         if ((mRow[d] % 2 == 1) && (mCol[d] % 2 == 1)) begin
            m = 32'h0;
            for (int dy = -1; dy <= 0; dy++)
               for (int dx = -1; dx <= 0; dx++)
                  if (win[d][mRow[d] + dy][mCol[d] + dx] > m)
                     m = win[d][mRow[d] + dy][mCol[d] + dx];
            drvValid[d] = 1'b1;
            drvData[d]  = m;
            drvDone[d]  = (mRow[d] == gH[d] - 1) && (mCol[d] == gW[d] - 1) &&
                          (mCh[d] == gC[d] - 1);
         end
         mCol[d]++;
         if (mCol[d] == gW[d]) begin
            mCol[d] = 0;
            mRow[d]++;
            if (mRow[d] == gH[d]) begin
               mRow[d] = 0;
               mCh[d]  = (mCh[d] + 1) % gC[d];
            end
         end
      end
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(0, 32'h0, 1'b0);
   endtask

   task automatic applyReset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         vIn[k] = 1'b0;
         mCol[k] = 0;
         mRow[k] = 0;
         mCh[k]  = 0;
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Move expectations into the cycle where the DUT must show them.
   always @(posedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (reset) begin
            expValid[d] = 1'b0;
            expDone[d]  = 1'b0;
            lastData[d] = 32'h0;
            drvValid[d] = 1'b0;
            drvDone[d]  = 1'b0;
         end else begin
            expValid[d] = drvValid[d];
            expData[d]  = drvData[d];
            expDone[d]  = drvDone[d];
            if (drvValid[d]) lastData[d] = drvData[d];
            drvValid[d] = 1'b0;
            drvDone[d]  = 1'b0;
         end
      end
   end

   // Compare every DUT against the model midway through each cycle.
   always @(negedge clk) begin
      for (int d = 0; d < NDUT; d++) begin
         if (vOut[d] === 1'b1) pulses[d]++;
         if (fDone[d] === 1'b1) dones[d]++;
         if (vOut[d] === 1'b1 && d == 0) cap0.push_back(pOut[d]);
         if (vOut[d] === 1'b1 && d == 1) cap1.push_back(pOut[d]);
         if (expValid[d] || vOut[d] !== 1'b0)
            checkOutput($sformatf("valid_out%0d", d), 32'(vOut[d]), 32'(expValid[d]));
         if (expValid[d])
            checkOutput($sformatf("pxl_out%0d", d), pOut[d], expData[d]);
         else
            checkOutput($sformatf("pxl_hold%0d", d), pOut[d], lastData[d]);
         if (expDone[d] || fDone[d] !== 1'b0)
            checkOutput($sformatf("frame_done%0d", d), 32'(fDone[d]), 32'(expDone[d]));
      end
   end

   logic [31:0] base[4];
   int          seen;

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
         vIn[k] = 1'b0;
         pIn[k] = 32'h0;
         drvValid[k] = 1'b0;
         drvDone[k]  = 1'b0;
         drvData[k]  = 32'h0;
         expValid[k] = 1'b0;
         expDone[k]  = 1'b0;
         expData[k]  = 32'h0;
         lastData[k] = 32'h0;
         pulses[k] = 0;
         dones[k]  = 0;
         mCol[k] = 0;
         mRow[k] = 0;
         mCh[k]  = 0;
      end
      base[0] = 32'h40C0_0000;
      base[1] = 32'h4100_0000;
      base[2] = 32'h4160_0000;
      base[3] = 32'h4180_0000;

      applyReset();
      @(negedge clk);
      for (int d = 0; d < NDUT; d++) begin
         checkOutput("rst_valid", 32'(vOut[d]), 32'h0);
         checkOutput("rst_pxl", pOut[d], 32'h0);
         checkOutput("rst_done", 32'(fDone[d]), 32'h0);
      end

      // 1: 4x4 raster 1.0..16.0 without gaps.
      $display("[TB] raster frame");
      cap0.delete();
      dones[0] = 0;
      for (int i = 1; i <= 16; i++) applyStimulus(0, floatOfInt(i), 1'b1);
      idleCycles(3);
      checkOutput("t1_count", 32'(cap0.size()), 32'd4);
      for (int j = 0; j < 4; j++)
         if (j < cap0.size()) checkOutput($sformatf("t1_val%0d", j), cap0[j], base[j]);
      checkOutput("t1_done", 32'(dones[0]), 32'd1);

      // 2: negative values and a negative zero all pool to +0.
      $display("[TB] negative frame");
      cap0.delete();
      for (int i = 0; i < 16; i++)
         applyStimulus(0, (i == 5) ? 32'h8000_0000 : 32'hC060_0000, 1'b1);
      idleCycles(3);
      checkOutput("t2_count", 32'(cap0.size()), 32'd4);
      foreach (cap0[j]) checkOutput($sformatf("t2_val%0d", j), cap0[j], 32'h0);

      // 3: same raster with valid_in toggling every cycle.
      $display("[TB] gapped raster");
      cap0.delete();
      for (int i = 1; i <= 16; i++) begin
         applyStimulus(0, floatOfInt(i), 1'b1);
         applyStimulus(0, $urandom, 1'b0);
      end
      idleCycles(3);
      checkOutput("t3_count", 32'(cap0.size()), 32'd4);
      for (int j = 0; j < 4; j++)
         if (j < cap0.size()) checkOutput($sformatf("t3_val%0d", j), cap0[j], base[j]);

      // 4: three contiguous channels, scaled copies of the raster.
      $display("[TB] three channels");
      cap1.delete();
      dones[1] = 0;
      for (int k = 0; k < 3; k++)
         for (int i = 1; i <= 16; i++) applyStimulus(1, floatOfInt((k + 1) * i), 1'b1);
      idleCycles(3);
      checkOutput("t4_count", 32'(cap1.size()), 32'd12);
      for (int k = 0; k < 3; k++)
         for (int j = 0; j < 4; j++)
            if (k * 4 + j < cap1.size())
               checkOutput($sformatf("t4_val%0d", k * 4 + j), cap1[k * 4 + j],
                           floatOfInt((k + 1) * ((j < 2) ? 6 + 2 * j : 14 + 2 * (j - 2))));
      checkOutput("t4_done", 32'(dones[1]), 32'd1);

      // 5: reset in the middle of a frame, then a clean frame.
      $display("[TB] reset mid-frame");
      for (int i = 1; i <= 9; i++) applyStimulus(0, floatOfInt(100 + i), 1'b1);
      applyReset();
      cap0.delete();
      dones[0] = 0;
      for (int i = 1; i <= 16; i++) applyStimulus(0, floatOfInt(i), 1'b1);
      idleCycles(3);
      checkOutput("t5_count", 32'(cap0.size()), 32'd4);
      for (int j = 0; j < 4; j++)
         if (j < cap0.size()) checkOutput($sformatf("t5_val%0d", j), cap0[j], base[j]);
      checkOutput("t5_done", 32'(dones[0]), 32'd1);

      // 6: large random frame with random gaps on the 16x16 instance.
      $display("[TB] random frame");
      applyReset();
      pulses[2] = 0;
      dones[2]  = 0;
      seen = 0;
      while (seen < 16 * 16 * 24) begin
         if ($urandom_range(3, 0) != 0) begin
            applyStimulus(2, $urandom, 1'b1);
            seen++;
         end else begin
            applyStimulus(2, $urandom, 1'b0);
         end
      end
      for (int i = 0; i < 3; i++) applyStimulus(2, 32'h0, 1'b0);
      checkOutput("t6_pulses", 32'(pulses[2]), 32'(24 * 64));
      checkOutput("t6_done", 32'(dones[2]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL timeout got running expected finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
